// File: rtl/board_io_bridge_if.sv
// Board I/O bundle between the pads/fabric side and board_io_bridge.
// The slave modport is the bridge's view; master is the fabric/pad driver's view.
interface board_io_bridge_if #(
   parameter int unsigned N_PB  = 2,
   parameter int unsigned N_LED = 8
);
   logic [N_PB-1:0]    pb_raw;
   logic [N_PB-1:0]    pb_level;
   logic [N_PB-1:0]    pb_press;
   logic [N_PB-1:0]    pb_release;
   logic [2*N_LED-1:0] led_mode;
   logic [N_LED-1:0]   led_fabric;
   logic [N_LED-1:0]   led_pad;
   logic               heartbeat;

   modport slave (
      input  pb_raw, led_mode, led_fabric,
      output pb_level, pb_press, pb_release, led_pad, heartbeat
   );

   modport master (
      output pb_raw, led_mode, led_fabric,
      input  pb_level, pb_press, pb_release, led_pad, heartbeat
   );
endinterface

// File: rtl/board_io_bridge.sv
// Board-side pushbutton conditioning (capture, sync, debounce, edge pulses)
// and per-LED mode mux with polarity handling plus a heartbeat blink counter.
module board_io_bridge #(
   parameter int unsigned N_PB           = 2,
   parameter int unsigned N_LED          = 8,
   parameter int unsigned DEB_CYCLES     = 1000000,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned BLINK_BIT      = 26,
   parameter bit          PB_ACTIVE_LOW  = 1'b1,
   parameter bit          LED_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   board_io_bridge_if.slave io
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [N_LED-1:0] LED_OFF  = {N_LED{LED_ACTIVE_LOW}};

   logic [N_PB-1:0]             pad_q;
   logic [N_PB-1:0]             sync1_q;
   logic [N_PB-1:0]             sync2_q;
   logic [N_PB-1:0]             level_q,   level_d;
   logic [N_PB-1:0]             press_q,   press_d;
   logic [N_PB-1:0]             release_q, release_d;
   logic [N_PB-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0]            blink_cnt_q;
   logic [N_LED-1:0]            led_pad_q, led_pad_d;
   logic [N_PB-1:0]             pb_norm_c;
   logic [N_LED-1:0]            led_v_c;
   logic                        blink_c;
   logic                        unused_cnt_bits;

   assign pb_norm_c       = PB_ACTIVE_LOW ? ~io.pb_raw : io.pb_raw;
   assign blink_c         = blink_cnt_q[BLINK_BIT];
   assign unused_cnt_bits = ^blink_cnt_q;

   // Pad capture flop followed by a 2-FF synchroniser; sync2_q is the debounce input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         pad_q   <= pb_norm_c;
         sync1_q <= pad_q;
         sync2_q <= sync1_q;
      end
   end

   // Level only moves after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = deb_cnt_q;
      for (int unsigned c = 0; c < N_PB; c++) begin
         if (sync2_q[c] == level_q[c]) begin
            deb_cnt_d[c] = '0;
         end else if (deb_cnt_q[c] == DEB_LAST) begin
            level_d[c]   = sync2_q[c];
            deb_cnt_d[c] = '0;
         end else begin
            deb_cnt_d[c] = deb_cnt_q[c] + DEB_W'(1);
         end
      end
      press_d   = level_d & ~level_q;
      release_d = level_q & ~level_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         deb_cnt_q <= '0;
      end else begin
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Free-running blink source; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
      end else begin
         blink_cnt_q <= blink_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      led_v_c = '0;
      for (int unsigned i = 0; i < N_LED; i++) begin
         unique case (io.led_mode[2*i +: 2])
            2'b00:   led_v_c[i] = 1'b0;
            2'b01:   led_v_c[i] = 1'b1;
            2'b10:   led_v_c[i] = io.led_fabric[i];
            default: led_v_c[i] = blink_c;
         endcase
      end
      led_pad_d = LED_ACTIVE_LOW ? ~led_v_c : led_v_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_pad_q <= LED_OFF;
      end else begin
         led_pad_q <= led_pad_d;
      end
   end

   assign io.pb_level   = level_q;
   assign io.pb_press   = press_q;
   assign io.pb_release = release_q;
   assign io.led_pad    = led_pad_q;
   assign io.heartbeat  = blink_cnt_q[BLINK_BIT];

endmodule

// File: tb/tb_board_io_bridge.sv
// Testbench for board_io_bridge: directed scenarios plus randomized pushbutton and
// LED-mode traffic, compared every cycle against a window-based reference model.
module tb_board_io_bridge;

   localparam int unsigned N_PB      = 2;
   localparam int unsigned N_LED     = 4;
   localparam int unsigned DEB       = 4;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned BLINK_BIT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic chk_en;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   board_io_bridge_if #(.N_PB(N_PB), .N_LED(N_LED)) bus ();

   board_io_bridge #(
      .N_PB          (N_PB),
      .N_LED         (N_LED),
      .DEB_CYCLES    (DEB),
      .CNT_W         (CNT_W),
      .BLINK_BIT     (BLINK_BIT),
      .PB_ACTIVE_LOW (1'b1),
      .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the input reaches the debouncer 3 edges after capture; a level
   // flips once the last DEB debouncer samples all disagree with it.
   logic [2:0][N_PB-1:0]     m_pipe_q, m_pipe_d;
   logic [DEB-1:0][N_PB-1:0] m_win_q, m_win_d;
   logic [N_PB-1:0]          m_level_q, m_level_d;
   logic [N_PB-1:0]          m_press_q, m_press_d;
   logic [N_PB-1:0]          m_rel_q, m_rel_d;
   logic [CNT_W-1:0]         m_cnt_q, m_cnt_d;
   logic [N_LED-1:0]         m_led_q, m_led_d;
   logic [N_LED-1:0]         m_v;
   logic                     m_all_diff;
   logic [1:0]               m_mode;

   always_comb begin
      m_pipe_d   = {m_pipe_q[1:0], ~bus.pb_raw};
      m_win_d    = {m_win_q[DEB-2:0], m_pipe_q[2]};
      m_level_d  = m_level_q;
      m_all_diff = 1'b0;
      for (int c = 0; c < int'(N_PB); c++) begin
         m_all_diff = 1'b1;
         for (int k = 0; k < int'(DEB); k++)
            if (m_win_d[k][c] == m_level_q[c]) m_all_diff = 1'b0;
         if (m_all_diff) m_level_d[c] = ~m_level_q[c];
      end
      m_press_d = m_level_d & ~m_level_q;
      m_rel_d   = m_level_q & ~m_level_d;
      m_cnt_d   = m_cnt_q + 1;
      m_v       = '0;
      m_mode    = 2'b00;
      for (int i = 0; i < int'(N_LED); i++) begin
         m_mode = bus.led_mode[2*i +: 2];
         if (m_mode == 2'd0)      m_v[i] = 1'b0;
         else if (m_mode == 2'd1) m_v[i] = 1'b1;
         else if (m_mode == 2'd2) m_v[i] = bus.led_fabric[i];
         else                     m_v[i] = m_cnt_q[BLINK_BIT];
      end
      m_led_d = ~m_v;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pipe_q  <= '0;
         m_win_q   <= '0;
         m_level_q <= '0;
         m_press_q <= '0;
         m_rel_q   <= '0;
         m_cnt_q   <= '0;
         m_led_q   <= '1;
      end else begin
         m_pipe_q  <= m_pipe_d;
         m_win_q   <= m_win_d;
         m_level_q <= m_level_d;
         m_press_q <= m_press_d;
         m_rel_q   <= m_rel_d;
         m_cnt_q   <= m_cnt_d;
         m_led_q   <= m_led_d;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pb_level",   32'(bus.pb_level),   32'(m_level_q));
         check("pb_press",   32'(bus.pb_press),   32'(m_press_q));
         check("pb_release", 32'(bus.pb_release), 32'(m_rel_q));
         check("led_pad",    32'(bus.led_pad),    32'(m_led_q));
         check("heartbeat",  32'(bus.heartbeat),  32'(m_cnt_q[BLINK_BIT]));
         check("press_rel_excl", 32'(bus.pb_press & bus.pb_release), 32'd0);
      end
   end

   initial begin
      rst_n          = 1'b0;
      chk_en         = 1'b0;
      bus.pb_raw     = '1;
      bus.led_mode   = '0;
      bus.led_fabric = '0;

      repeat (3) @(negedge clk);
      check("rst_level", 32'(bus.pb_level),  32'd0);
      check("rst_led",   32'(bus.led_pad),   32'hF);
      check("rst_hb",    32'(bus.heartbeat), 32'd0);
      chk_en = 1'b1;
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_level", 32'(bus.pb_level), 32'd0);
      check("post_rst_led",   32'(bus.led_pad),  32'hF);

      // Clean press on ch0: level and press pulse land on edge 2+DEB.
      bus.pb_raw[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("s2_level_e5", 32'(bus.pb_level[0]), 32'd0);
      @(negedge clk);
      check("s2_level_e6", 32'(bus.pb_level[0]), 32'd1);
      check("s2_press_e6", 32'(bus.pb_press[0]), 32'd1);
      @(negedge clk);
      check("s2_press_e7", 32'(bus.pb_press[0]), 32'd0);

      // Short glitch on ch1 must not register.
      bus.pb_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      bus.pb_raw[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("s3_glitch_level", 32'(bus.pb_level[1]), 32'd0);
         check("s3_glitch_press", 32'(bus.pb_press[1]), 32'd0);
      end

      // Simultaneous ch0 release and ch1 press.
      bus.pb_raw = 2'b01;
      repeat (7) @(negedge clk);
      check("s4_rel0",   32'(bus.pb_release[0]), 32'd1);
      check("s4_press1", 32'(bus.pb_press[1]),   32'd1);
      check("s4_level",  32'(bus.pb_level),      32'd2);
      bus.pb_raw = 2'b11;
      repeat (10) @(negedge clk);

      // LED modes: off, on, fabric, blink.
      bus.led_mode   = 8'b11_10_01_00;
      bus.led_fabric = 4'b0100;
      @(negedge clk);
      check("s5_led_low", 32'(bus.led_pad[2:0]), 32'b001);
      repeat (24) @(negedge clk);

      // Reset mid-debounce discards the partial count.
      bus.pb_raw[0] = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("s6_rst_level", 32'(bus.pb_level[0]), 32'd0);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("s6_level_e5", 32'(bus.pb_level[0]), 32'd0);
      @(negedge clk);
      check("s6_level_e6", 32'(bus.pb_level[0]), 32'd1);
      bus.pb_raw = 2'b11;
      repeat (10) @(negedge clk);

      // Randomized traffic: bouncy buttons of varying hold times, random LED modes.
      for (int it = 0; it < 400; it++) begin
         bus.pb_raw = N_PB'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            bus.led_mode   = (2*N_LED)'($urandom);
            bus.led_fabric = N_LED'($urandom);
         end
         repeat ($urandom_range(1, 9)) @(negedge clk);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
